axi_mem_arbiter: RTL and testbench
==================================

Name: axi_mem_arbiter

Overview:
- Sits between the pipeline caches and the single AXI4 RAM slave. It shares that slave between three requesters: the I-cache refill read, the D-cache refill read and the D-cache writeback write.
- Sequences AR/R and AW/W/B as full AXI4 master handshakes.
- Allows one outstanding read and one outstanding write.
- Orders D-cache reads behind any in-flight D-cache write.

Parameters:
ADDR_WIDTH, 32, address width of AXI and requester ports
DATA_WIDTH, 32, data width; AxSIZE = log2(DATA_WIDTH/8)
ID_WIDTH, 1, AXI ID width; ID 0 = I-cache, 1 = D-cache

Ports:
S_AXI_ACLK  in  1  clock
rst  in  1  synchronous active-high reset
ic_rd_req / dc_rd_req  in  1  read request; held with addr/len until gnt
ic_rd_addr / dc_rd_addr  in  ADDR_WIDTH  burst start byte address
ic_rd_len / dc_rd_len  in  8  AXI LEN (beats-1)
ic_rd_gnt / dc_rd_gnt  out  1  one-cycle accept pulse
ic_rd_valid / dc_rd_valid  out  1  returned beat valid
ic_rd_data / dc_rd_data  out  DATA_WIDTH  returned beat data
ic_rd_last / dc_rd_last  out  1  final beat
dc_wr_req  in  1  writeback request; held until dc_wr_gnt
dc_wr_addr  in  ADDR_WIDTH  write start address
dc_wr_len  in  8  AXI LEN
dc_wr_gnt  out  1  accept pulse
dc_wr_data  in  DATA_WIDTH  current write beat
dc_wr_strb  in  DATA_WIDTH/8  byte strobes
dc_wr_dready  out  1  current beat consumed; requester advances
dc_wr_done  out  1  one-cycle pulse on B handshake
M_AXI_AR{ID,ADDR,LEN,SIZE,BURST,VALID}  out  per AXI4  read address
M_AXI_ARREADY  in  1
M_AXI_R{ID,DATA,RESP,LAST,VALID}  in  per AXI4  read data
M_AXI_RREADY  out  1
M_AXI_AW{ID,ADDR,LEN,SIZE,BURST,VALID}  out  per AXI4  write address
M_AXI_AWREADY  in  1
M_AXI_W{DATA,STRB,LAST,VALID}  out  per AXI4  write data
M_AXI_WREADY  in  1
M_AXI_B{ID,RESP,VALID}  in  per AXI4  write response
M_AXI_BREADY  out  1

Behaviour:
- Reset: both FSMs go to IDLE and every VALID/READY/gnt/done output is 0. rr_last = 1 (D-cache), so the I-cache wins the first tie.
- Reset mid-burst abandons the transaction without completion pulses. The slave shares the same reset.
- AxBURST = INCR (2'b01) and AxSIZE = log2(DATA_WIDTH/8) always. AxID = owner.

Read FSM R_IDLE -> R_AR -> R_DATA:
- R_IDLE arbitration:
  - Eligible requesters are ic_rd_req, and dc_rd_req only while the write FSM is in W_IDLE and dc_wr_req = 0.
  - If both are eligible, round-robin: the one not equal to rr_last wins. rr_last updates to the winner.
  - On a win: latch owner, addr and len; the winner's gnt = 1 in that cycle; go to R_AR.
- R_AR: ARVALID = 1 with latched fields, held stable until ARREADY. Then go to R_DATA.
- R_DATA:
  - RREADY = 1. Each RVALID beat routes RDATA/RLAST to the owner's port (valid = RVALID) in the same cycle.
  - The other port's valid stays 0.
  - On RVALID & RLAST, return to R_IDLE. The next grant is possible in the following cycle.
- RRESP and RID are ignored.

Write FSM W_IDLE -> W_AW -> W_DATA -> W_RESP:
- W_IDLE: dc_wr_req -> latch addr/len, dc_wr_gnt = 1, beat counter = 0, go to W_AW.
- W_AW: AWVALID = 1 until AWREADY, then go to W_DATA. W is not driven before AW completes.
- W_DATA:
  - WVALID = 1, WDATA/WSTRB = dc_wr_data/strb (pass-through), WLAST = (cnt == len).
  - dc_wr_dready = WVALID & WREADY.
  - On each handshake, cnt++. A handshake with WLAST goes to W_RESP.
- W_RESP: BREADY = 1. On BVALID, dc_wr_done = 1 and go to W_IDLE.

Concurrency and ordering:
- Read and write FSMs run concurrently, so an I-cache read may overlap a writeback.
- If dc_wr_req and dc_rd_req are both high in the same cycle, the write wins. The D-cache read is granted no earlier than the cycle after dc_wr_done (read-after-write ordering).
- len = 0 is a single beat: WLAST/RLAST on the first beat.
- cnt is 8 bits; len = 255 gives 256 beats with no overflow before WLAST.

Test Plan:
- RAM preloaded 24010001, 00011100, 00411821, 00022082 at 0x0–0xC. ic_rd_req addr 0x0 len 3 -> one AR (ARID 0, ARLEN 3). ic_rd_valid on 4 beats with those words; ic_rd_last only on the 4th.
- ic and dc read requests in the same cycle after reset -> I-cache granted first. When both request again after it completes -> D-cache granted (round-robin alternation).
- dc_wr_req addr 0x40 len 1 (data AAAA5555, 12345678, strb F) plus dc_rd_req addr 0x40 len 1 in the same cycle -> write first; AR issued only after dc_wr_done. Read returns AAAA5555, 12345678.
- Partial strobe: write 0x11223344 strb 4'b0011 to 0x0 (was 24010001) -> subsequent read returns 0x24013344.
- Hold ARREADY/AWREADY low 5 cycles -> VALID and all fields stable throughout; no gnt re-pulse; completion after release.
- Assert rst for one cycle during beat 2 of a len-3 read -> all outputs 0 next cycle, FSMs IDLE, no ic_rd_last. A fresh request then completes normally.

Source files
------------

// File: rtl/axi_mem_arbiter.sv
// Shares one AXI4 RAM slave between I-cache refill, D-cache refill and D-cache writeback.
// One outstanding read and one outstanding write; D-cache reads are ordered behind writebacks.
module axi_mem_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 1
) (
    input  logic                      S_AXI_ACLK,
    input  logic                      rst,

    input  logic                      ic_rd_req,
    input  logic [ADDR_WIDTH-1:0]     ic_rd_addr,
    input  logic [7:0]                ic_rd_len,
    output logic                      ic_rd_gnt,
    output logic                      ic_rd_valid,
    output logic [DATA_WIDTH-1:0]     ic_rd_data,
    output logic                      ic_rd_last,

    input  logic                      dc_rd_req,
    input  logic [ADDR_WIDTH-1:0]     dc_rd_addr,
    input  logic [7:0]                dc_rd_len,
    output logic                      dc_rd_gnt,
    output logic                      dc_rd_valid,
    output logic [DATA_WIDTH-1:0]     dc_rd_data,
    output logic                      dc_rd_last,

    input  logic                      dc_wr_req,
    input  logic [ADDR_WIDTH-1:0]     dc_wr_addr,
    input  logic [7:0]                dc_wr_len,
    output logic                      dc_wr_gnt,
    input  logic [DATA_WIDTH-1:0]     dc_wr_data,
    input  logic [DATA_WIDTH/8-1:0]   dc_wr_strb,
    output logic                      dc_wr_dready,
    output logic                      dc_wr_done,

    output logic [ID_WIDTH-1:0]       M_AXI_ARID,
    output logic [ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [7:0]                M_AXI_ARLEN,
    output logic [2:0]                M_AXI_ARSIZE,
    output logic [1:0]                M_AXI_ARBURST,
    output logic                      M_AXI_ARVALID,
    input  logic                      M_AXI_ARREADY,
    input  logic [ID_WIDTH-1:0]       M_AXI_RID,
    input  logic [DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                M_AXI_RRESP,
    input  logic                      M_AXI_RLAST,
    input  logic                      M_AXI_RVALID,
    output logic                      M_AXI_RREADY,

    output logic [ID_WIDTH-1:0]       M_AXI_AWID,
    output logic [ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [7:0]                M_AXI_AWLEN,
    output logic [2:0]                M_AXI_AWSIZE,
    output logic [1:0]                M_AXI_AWBURST,
    output logic                      M_AXI_AWVALID,
    input  logic                      M_AXI_AWREADY,
    output logic [DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                      M_AXI_WLAST,
    output logic                      M_AXI_WVALID,
    input  logic                      M_AXI_WREADY,
    input  logic [ID_WIDTH-1:0]       M_AXI_BID,
    input  logic [1:0]                M_AXI_BRESP,
    input  logic                      M_AXI_BVALID,
    output logic                      M_AXI_BREADY
);

    localparam logic [2:0] AxSize  = 3'($clog2(DATA_WIDTH / 8));
    localparam logic [1:0] AxBurst = 2'b01;

    typedef enum logic [1:0] {RIdle, RAr, RData} r_state_e;
    typedef enum logic [1:0] {WIdle, WAw, WData, WResp} w_state_e;

    r_state_e              r_state_q, r_state_d;
    logic                  owner_q, owner_d;      // 0 = I-cache, 1 = D-cache
    logic                  rr_last_q, rr_last_d;
    logic [ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d;
    logic [7:0]            ar_len_q, ar_len_d;

    w_state_e              w_state_q, w_state_d;
    logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
    logic [7:0]            aw_len_q, aw_len_d;
    logic [7:0]            wr_cnt_q, wr_cnt_d;

    logic dc_rd_elig, pick_ic, pick_dc, wr_last;

    logic unused_inputs;
    assign unused_inputs = ^{M_AXI_RID, M_AXI_RRESP, M_AXI_BID, M_AXI_BRESP};

    // Read arbitration: D-cache reads wait for any pending or in-flight writeback.
    always_comb begin
        dc_rd_elig = dc_rd_req && (w_state_q == WIdle) && !dc_wr_req;
        pick_ic    = 1'b0;
        pick_dc    = 1'b0;
        if (r_state_q == RIdle && !rst) begin
            if (ic_rd_req && dc_rd_elig) begin
                pick_ic = rr_last_q;
                pick_dc = !rr_last_q;
            end else begin
                pick_ic = ic_rd_req;
                pick_dc = dc_rd_elig;
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (rst) begin
            r_state_q <= RIdle;
            owner_q   <= 1'b0;
            rr_last_q <= 1'b1;
            ar_addr_q <= '0;
            ar_len_q  <= '0;
        end else begin
            r_state_q <= r_state_d;
            owner_q   <= owner_d;
            rr_last_q <= rr_last_d;
            ar_addr_q <= ar_addr_d;
            ar_len_q  <= ar_len_d;
        end
    end

    always_comb begin
        r_state_d = r_state_q;
        owner_d   = owner_q;
        rr_last_d = rr_last_q;
        ar_addr_d = ar_addr_q;
        ar_len_d  = ar_len_q;
        unique case (r_state_q)
            RIdle: begin
                if (pick_ic || pick_dc) begin
                    r_state_d = RAr;
                    owner_d   = pick_dc;
                    rr_last_d = pick_dc;
                    ar_addr_d = pick_dc ? dc_rd_addr : ic_rd_addr;
                    ar_len_d  = pick_dc ? dc_rd_len : ic_rd_len;
                end
            end
            RAr:     if (M_AXI_ARREADY) r_state_d = RData;
            RData:   if (M_AXI_RVALID && M_AXI_RLAST) r_state_d = RIdle;
            default: r_state_d = RIdle;
        endcase
    end

    always_comb begin
        ic_rd_gnt     = pick_ic;
        dc_rd_gnt     = pick_dc;
        M_AXI_ARVALID = (r_state_q == RAr);
        M_AXI_RREADY  = (r_state_q == RData);
        ic_rd_valid   = (r_state_q == RData) && M_AXI_RVALID && !owner_q;
        dc_rd_valid   = (r_state_q == RData) && M_AXI_RVALID && owner_q;
        ic_rd_last    = ic_rd_valid && M_AXI_RLAST;
        dc_rd_last    = dc_rd_valid && M_AXI_RLAST;
    end

    assign ic_rd_data    = M_AXI_RDATA;
    assign dc_rd_data    = M_AXI_RDATA;
    assign M_AXI_ARID    = ID_WIDTH'(owner_q);
    assign M_AXI_ARADDR  = ar_addr_q;
    assign M_AXI_ARLEN   = ar_len_q;
    assign M_AXI_ARSIZE  = AxSize;
    assign M_AXI_ARBURST = AxBurst;

    always_ff @(posedge S_AXI_ACLK) begin
        if (rst) begin
            w_state_q <= WIdle;
            aw_addr_q <= '0;
            aw_len_q  <= '0;
            wr_cnt_q  <= '0;
        end else begin
            w_state_q <= w_state_d;
            aw_addr_q <= aw_addr_d;
            aw_len_q  <= aw_len_d;
            wr_cnt_q  <= wr_cnt_d;
        end
    end

    assign wr_last = (wr_cnt_q == aw_len_q);

    always_comb begin
        w_state_d = w_state_q;
        aw_addr_d = aw_addr_q;
        aw_len_d  = aw_len_q;
        wr_cnt_d  = wr_cnt_q;
        unique case (w_state_q)
            WIdle: begin
                if (dc_wr_req) begin
                    w_state_d = WAw;
                    aw_addr_d = dc_wr_addr;
                    aw_len_d  = dc_wr_len;
                    wr_cnt_d  = 8'd0;
                end
            end
            WAw: if (M_AXI_AWREADY) w_state_d = WData;
            WData: begin
                if (M_AXI_WREADY) begin
                    wr_cnt_d = wr_cnt_q + 8'd1;
                    if (wr_last) w_state_d = WResp;
                end
            end
            WResp:   if (M_AXI_BVALID) w_state_d = WIdle;
            default: w_state_d = WIdle;
        endcase
    end

    always_comb begin
        dc_wr_gnt     = (w_state_q == WIdle) && dc_wr_req && !rst;
        M_AXI_AWVALID = (w_state_q == WAw);
        M_AXI_WVALID  = (w_state_q == WData);
        M_AXI_WLAST   = (w_state_q == WData) && wr_last;
        dc_wr_dready  = (w_state_q == WData) && M_AXI_WREADY;
        M_AXI_BREADY  = (w_state_q == WResp);
        dc_wr_done    = (w_state_q == WResp) && M_AXI_BVALID;
    end

    assign M_AXI_AWID    = ID_WIDTH'(1);
    assign M_AXI_AWADDR  = aw_addr_q;
    assign M_AXI_AWLEN   = aw_len_q;
    assign M_AXI_AWSIZE  = AxSize;
    assign M_AXI_AWBURST = AxBurst;
    assign M_AXI_WDATA   = dc_wr_data;
    assign M_AXI_WSTRB   = dc_wr_strb;

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// Scoreboard bench for axi_mem_arbiter: behavioural AXI RAM slave, word-level memory model,
// directed ordering/stall/reset cases followed by concurrent randomized traffic.
module tb_axi_mem_arbiter;
    localparam int TMO = 3000;

    logic        clk = 1'b0;
    logic        rst;
    logic        ic_rd_req, dc_rd_req, dc_wr_req;
    logic [31:0] ic_rd_addr, dc_rd_addr, dc_wr_addr, dc_wr_data;
    logic [7:0]  ic_rd_len, dc_rd_len, dc_wr_len;
    logic [3:0]  dc_wr_strb;
    logic        ic_rd_gnt, ic_rd_valid, ic_rd_last, dc_rd_gnt, dc_rd_valid, dc_rd_last;
    logic [31:0] ic_rd_data, dc_rd_data;
    logic        dc_wr_gnt, dc_wr_dready, dc_wr_done;
    logic [0:0]  arid, rid, awid, bid;
    logic [31:0] araddr, awaddr, rdata, wdata;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize;
    logic [1:0]  arburst, awburst, rresp, bresp;
    logic        arvalid, arready, rlast, rvalid, rready, awvalid, awready;
    logic [3:0]  wstrb;
    logic        wlast, wvalid, wready, bvalid, bready;

    always #5 clk = ~clk;

    axi_mem_arbiter dut (
        .S_AXI_ACLK(clk), .rst(rst),
        .ic_rd_req(ic_rd_req), .ic_rd_addr(ic_rd_addr), .ic_rd_len(ic_rd_len),
        .ic_rd_gnt(ic_rd_gnt), .ic_rd_valid(ic_rd_valid), .ic_rd_data(ic_rd_data),
        .ic_rd_last(ic_rd_last),
        .dc_rd_req(dc_rd_req), .dc_rd_addr(dc_rd_addr), .dc_rd_len(dc_rd_len),
        .dc_rd_gnt(dc_rd_gnt), .dc_rd_valid(dc_rd_valid), .dc_rd_data(dc_rd_data),
        .dc_rd_last(dc_rd_last),
        .dc_wr_req(dc_wr_req), .dc_wr_addr(dc_wr_addr), .dc_wr_len(dc_wr_len),
        .dc_wr_gnt(dc_wr_gnt), .dc_wr_data(dc_wr_data), .dc_wr_strb(dc_wr_strb),
        .dc_wr_dready(dc_wr_dready), .dc_wr_done(dc_wr_done),
        .M_AXI_ARID(arid), .M_AXI_ARADDR(araddr), .M_AXI_ARLEN(arlen), .M_AXI_ARSIZE(arsize),
        .M_AXI_ARBURST(arburst), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RID(rid), .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RLAST(rlast),
        .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready),
        .M_AXI_AWID(awid), .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen), .M_AXI_AWSIZE(awsize),
        .M_AXI_AWBURST(awburst), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast), .M_AXI_WVALID(wvalid),
        .M_AXI_WREADY(wready),
        .M_AXI_BID(bid), .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready)
    );

    logic [13:0] ctl_outs;
    assign ctl_outs = {ic_rd_gnt, dc_rd_gnt, ic_rd_valid, dc_rd_valid, ic_rd_last, dc_rd_last,
                       dc_wr_gnt, dc_wr_dready, dc_wr_done, arvalid, rready, awvalid, wvalid,
                       bready};

    int n_checks = 0;
    int n_err = 0;
    int cyc = 0;
    int ic_gnt_cyc, dc_gnt_cyc, done_cyc, dc_ar_cyc;
    logic hold_ar = 1'b0;
    logic hold_aw = 1'b0;

    logic [31:0] ref_mem [0:1023];
    logic [31:0] smem [0:1023];
    logic [31:0] wr_beats [0:255];
    logic [3:0]  wr_strbs [0:255];
    logic [32:0] ic_exp[$], dc_exp[$];   // {last, data}
    logic [39:0] ar_exp_ic[$], ar_exp_dc[$], aw_exp[$];   // {len, addr}

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void model_read(input int who, input logic [31:0] addr, input int len);
        for (int i = 0; i <= len; i++) begin
            logic [9:0] idx;
            idx = 10'((addr >> 2) + 32'(i));
            if (who == 0) ic_exp.push_back({i == len, ref_mem[idx]});
            else dc_exp.push_back({i == len, ref_mem[idx]});
        end
        if (who == 0) ar_exp_ic.push_back({8'(len), addr});
        else ar_exp_dc.push_back({8'(len), addr});
    endfunction

    function automatic void model_write(input logic [31:0] addr, input int len);
        for (int i = 0; i <= len; i++) begin
            logic [9:0] idx;
            idx = 10'((addr >> 2) + 32'(i));
            for (int b = 0; b < 4; b++)
                if (wr_strbs[i][b]) ref_mem[idx][8*b +: 8] = wr_beats[i][8*b +: 8];
        end
        aw_exp.push_back({8'(len), addr});
    endfunction

    task automatic rd_req(input int who, input logic [31:0] addr, input int len);
        int t;
        @(posedge clk); #1;
        if (who == 0) begin ic_rd_req = 1; ic_rd_addr = addr; ic_rd_len = 8'(len); end
        else begin dc_rd_req = 1; dc_rd_addr = addr; dc_rd_len = 8'(len); end
        t = 0;
        do begin @(negedge clk); t++; end
        while (!((who == 0) ? ic_rd_gnt : dc_rd_gnt) && t < TMO);
        chk("rd_gnt_timeout", 64'(t >= TMO), 0);
        @(posedge clk); #1;
        if (who == 0) ic_rd_req = 0; else dc_rd_req = 0;
        t = 0;
        do begin @(negedge clk); t++; end
        while (!((who == 0) ? (ic_rd_valid && ic_rd_last) : (dc_rd_valid && dc_rd_last))
               && t < TMO);
        chk("rd_last_timeout", 64'(t >= TMO), 0);
    endtask

    task automatic wr_req(input logic [31:0] addr, input int len);
        int t;
        int beat;
        @(posedge clk); #1;
        dc_wr_req = 1; dc_wr_addr = addr; dc_wr_len = 8'(len);
        dc_wr_data = wr_beats[0]; dc_wr_strb = wr_strbs[0];
        t = 0;
        do begin @(negedge clk); t++; end while (!dc_wr_gnt && t < TMO);
        chk("wr_gnt_timeout", 64'(t >= TMO), 0);
        @(posedge clk); #1;
        dc_wr_req = 0;
        beat = 0;
        t = 0;
        while (beat <= len && t < TMO) begin
            @(negedge clk); t++;
            if (dc_wr_dready) begin
                beat++;
                @(posedge clk); #1;
                if (beat <= len) begin dc_wr_data = wr_beats[beat]; dc_wr_strb = wr_strbs[beat]; end
            end
        end
        chk("wr_beats_timeout", 64'(t >= TMO), 0);
        t = 0;
        do begin @(negedge clk); t++; end while (!dc_wr_done && t < TMO);
        chk("wr_done_timeout", 64'(t >= TMO), 0);
    endtask

    // Behavioural AXI4 RAM slave: observes at negedge, drives #1 after posedge.
    initial begin : slave
        logic rst_s, ar_hs, r_hs, aw_hs, w_hs, b_hs, wlast_s, rd_active, wr_active, b_pend;
        logic [31:0] araddr_s, awaddr_s, wdata_s, rd_addr, wr_addr;
        logic [3:0] wstrb_s;
        logic [0:0] arid_s, rd_id;
        int arlen_s, rd_left, wr_len, wr_cnt, awlen_s;
        for (int i = 0; i < 1024; i++) begin
            smem[i] = $urandom;
            ref_mem[i] = smem[i];
        end
        smem[0] = 32'h24010001; smem[1] = 32'h00011100;
        smem[2] = 32'h00411821; smem[3] = 32'h00022082;
        for (int i = 0; i < 4; i++) ref_mem[i] = smem[i];
        rd_active = 0; wr_active = 0; b_pend = 0; rd_addr = 0; rd_left = 0; rd_id = 0;
        wr_addr = 0; wr_len = 0; wr_cnt = 0;
        arready = 0; rvalid = 0; rdata = 0; rlast = 0; rid = 0; rresp = 0;
        awready = 0; wready = 0; bvalid = 0; bid = 1; bresp = 0;
        forever begin
            @(negedge clk);
            rst_s = rst;
            ar_hs = arvalid && arready; araddr_s = araddr; arlen_s = int'(arlen); arid_s = arid;
            r_hs = rvalid && rready;
            aw_hs = awvalid && awready; awaddr_s = awaddr; awlen_s = int'(awlen);
            w_hs = wvalid && wready; wdata_s = wdata; wstrb_s = wstrb; wlast_s = wlast;
            b_hs = bvalid && bready;
            @(posedge clk); #1;
            if (rst_s) begin
                rd_active = 0; wr_active = 0; b_pend = 0;
                arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
            end else begin
                if (r_hs) begin
                    if (rd_left == 0) rd_active = 0;
                    else begin rd_left--; rd_addr += 4; end
                end
                if (ar_hs) begin
                    rd_active = 1; rd_addr = araddr_s; rd_left = arlen_s; rd_id = arid_s;
                end
                if (b_hs) b_pend = 0;
                if (w_hs) begin
                    chk("w_before_aw", 64'(!wr_active), 0);
                    chk("wlast", 64'(wlast_s), 64'(wr_cnt == wr_len));
                    for (int b = 0; b < 4; b++)
                        if (wstrb_s[b]) smem[wr_addr[11:2]][8*b +: 8] = wdata_s[8*b +: 8];
                    wr_addr += 4; wr_cnt++;
                    if (wlast_s) begin wr_active = 0; b_pend = 1; end
                end
                if (aw_hs) begin wr_active = 1; wr_addr = awaddr_s; wr_len = awlen_s; wr_cnt = 0; end
                arready = !hold_ar && ($urandom_range(0, 2) != 0);
                if (!(rvalid && !r_hs)) rvalid = rd_active && ($urandom_range(0, 3) != 0);
                rdata = smem[rd_addr[11:2]]; rlast = (rd_left == 0); rid = rd_id;
                awready = !hold_aw && ($urandom_range(0, 2) != 0);
                wready = ($urandom_range(0, 2) != 0);
                if (!(bvalid && !b_hs)) bvalid = b_pend && ($urandom_range(0, 1) != 0);
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a beat or an address handshake.
    initial begin : monitor
        logic [32:0] e;
        logic [39:0] a;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (ic_rd_valid || dc_rd_valid)
                    chk("rd_valid_exclusive", 64'(ic_rd_valid && dc_rd_valid), 0);
                if (ic_rd_valid) begin
                    if (ic_exp.size() == 0) chk("ic_rd_extra_beat", 64'(ic_rd_valid), 0);
                    else begin
                        e = ic_exp.pop_front();
                        chk("ic_rd_data", ic_rd_data, e[31:0]);
                        chk("ic_rd_last", 64'(ic_rd_last), 64'(e[32]));
                    end
                end
                if (dc_rd_valid) begin
                    if (dc_exp.size() == 0) chk("dc_rd_extra_beat", 64'(dc_rd_valid), 0);
                    else begin
                        e = dc_exp.pop_front();
                        chk("dc_rd_data", dc_rd_data, e[31:0]);
                        chk("dc_rd_last", 64'(dc_rd_last), 64'(e[32]));
                    end
                end
                if (arvalid && arready) begin
                    chk("ar_size_burst", {arsize, arburst}, {3'd2, 2'b01});
                    if (arid == 1'b0 && ar_exp_ic.size() != 0) begin
                        a = ar_exp_ic.pop_front();
                        chk("ar_ic_fields", {arlen, araddr}, a);
                    end else if (arid == 1'b1 && ar_exp_dc.size() != 0) begin
                        a = ar_exp_dc.pop_front();
                        chk("ar_dc_fields", {arlen, araddr}, a);
                        dc_ar_cyc = cyc;
                    end else chk("ar_unexpected", 64'(arvalid), 0);
                end
                if (awvalid && awready) begin
                    chk("aw_size_burst", {awsize, awburst}, {3'd2, 2'b01});
                    if (aw_exp.size() == 0) chk("aw_unexpected", 64'(awvalid), 0);
                    else begin
                        a = aw_exp.pop_front();
                        chk("aw_fields", {awid, awlen, awaddr}, {1'b1, a});
                    end
                end
                if (ic_rd_gnt) ic_gnt_cyc = cyc;
                if (dc_rd_gnt) dc_gnt_cyc = cyc;
                if (dc_wr_done) done_cyc = cyc;
            end
        end
    end

    initial begin : stim
        int t;
        int ic_first;
        rst = 1;
        ic_rd_req = 0; ic_rd_addr = 0; ic_rd_len = 0;
        dc_rd_req = 0; dc_rd_addr = 0; dc_rd_len = 0;
        dc_wr_req = 0; dc_wr_addr = 0; dc_wr_len = 0; dc_wr_data = 0; dc_wr_strb = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("reset_outputs", 64'(ctl_outs), 0);

        // Tie after reset goes to the I-cache; a re-request while D-cache waits alternates.
        model_read(0, 32'h0, 3);
        model_read(0, 32'h30, 2);
        model_read(1, 32'h20, 1);
        fork
            begin rd_req(0, 32'h0, 3); ic_first = ic_gnt_cyc; rd_req(0, 32'h30, 2); end
            rd_req(1, 32'h20, 1);
        join
        chk("rr_first_ic", 64'(ic_first < dc_gnt_cyc), 1);
        chk("rr_alternate_dc", 64'(dc_gnt_cyc < ic_gnt_cyc), 1);

        // Simultaneous writeback and D-cache read to the same line: write must finish first.
        wr_beats[0] = 32'hAAAA5555; wr_beats[1] = 32'h12345678;
        wr_strbs[0] = 4'hF; wr_strbs[1] = 4'hF;
        model_write(32'h40, 1);
        model_read(1, 32'h40, 1);
        fork
            wr_req(32'h40, 1);
            rd_req(1, 32'h40, 1);
        join
        chk("raw_gnt_after_done", 64'(dc_gnt_cyc > done_cyc), 1);
        chk("raw_ar_after_done", 64'(dc_ar_cyc > done_cyc), 1);

        // Partial strobe merge
        wr_beats[0] = 32'h11223344; wr_strbs[0] = 4'b0011;
        model_write(32'h0, 0);
        wr_req(32'h0, 0);
        model_read(0, 32'h0, 0);
        rd_req(0, 32'h0, 0);

        // ARREADY held low: request fields stay put, no second grant.
        hold_ar = 1;
        model_read(0, 32'h10, 2);
        fork
            rd_req(0, 32'h10, 2);
            begin
                t = 0;
                do begin @(negedge clk); t++; end while (!arvalid && t < TMO);
                chk("ar_stall_timeout", 64'(t >= TMO), 0);
                repeat (5) begin
                    @(negedge clk);
                    chk("ar_stall_fields", {arvalid, arid, arlen, araddr},
                        {1'b1, 1'b0, 8'd2, 32'h10});
                    chk("ar_stall_no_regnt", 64'(ic_rd_gnt), 0);
                end
                hold_ar = 0;
            end
        join

        // AWREADY held low: W must stay idle, fields stable.
        hold_aw = 1;
        wr_beats[0] = 32'hCAFEF00D; wr_strbs[0] = 4'hF;
        model_write(32'h60, 0);
        fork
            wr_req(32'h60, 0);
            begin
                t = 0;
                do begin @(negedge clk); t++; end while (!awvalid && t < TMO);
                chk("aw_stall_timeout", 64'(t >= TMO), 0);
                repeat (5) begin
                    @(negedge clk);
                    chk("aw_stall_fields", {awvalid, wvalid, dc_wr_gnt, awlen, awaddr},
                        {1'b1, 1'b0, 1'b0, 8'd0, 32'h60});
                end
                hold_aw = 0;
            end
        join
        model_read(1, 32'h60, 0);
        rd_req(1, 32'h60, 0);

        // Reset in the middle of a burst abandons it silently.
        model_read(0, 32'h80, 3);
        @(posedge clk); #1;
        ic_rd_req = 1; ic_rd_addr = 32'h80; ic_rd_len = 8'd3;
        t = 0;
        do begin @(negedge clk); t++; end while (!ic_rd_gnt && t < TMO);
        chk("rst_gnt_timeout", 64'(t >= TMO), 0);
        @(posedge clk); #1;
        ic_rd_req = 0;
        t = 0;
        do begin @(negedge clk); t++; end while (!ic_rd_valid && t < TMO);
        chk("rst_beat_timeout", 64'(t >= TMO), 0);
        @(posedge clk); #1 rst = 1;
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        chk("rst_mid_outputs", 64'(ctl_outs), 0);
        ic_exp.delete();
        ar_exp_ic.delete();
        repeat (4) begin
            @(negedge clk);
            chk("rst_no_stale_beat", 64'({ic_rd_valid, ic_rd_last, rready}), 0);
        end
        model_read(0, 32'h80, 3);
        rd_req(0, 32'h80, 3);

        // Maximum burst length: 256 beats each way.
        for (int i = 0; i < 256; i++) begin wr_beats[i] = $urandom; wr_strbs[i] = 4'hF; end
        model_write(32'h800, 255);
        wr_req(32'h800, 255);
        model_read(1, 32'h800, 255);
        rd_req(1, 32'h800, 255);

        // Concurrent random traffic on disjoint regions, then read back the write region.
        fork
            for (int k = 0; k < 8; k++) begin
                automatic int a = $urandom_range(0, 63) * 4;
                automatic int l = $urandom_range(0, 7);
                repeat ($urandom_range(0, 3)) @(posedge clk);
                model_read(0, 32'(a), l);
                rd_req(0, 32'(a), l);
            end
            for (int k = 0; k < 8; k++) begin
                automatic int a = 32'h200 + $urandom_range(0, 63) * 4;
                automatic int l = $urandom_range(0, 7);
                repeat ($urandom_range(0, 3)) @(posedge clk);
                model_read(1, 32'(a), l);
                rd_req(1, 32'(a), l);
            end
            for (int k = 0; k < 6; k++) begin
                automatic int a = 32'h400 + $urandom_range(0, 63) * 4;
                automatic int l = $urandom_range(0, 7);
                repeat ($urandom_range(0, 3)) @(posedge clk);
                for (int i = 0; i <= l; i++) begin
                    wr_beats[i] = $urandom;
                    wr_strbs[i] = 4'($urandom_range(0, 15));
                end
                model_write(32'(a), l);
                wr_req(32'(a), l);
            end
        join
        model_read(1, 32'h400, 127);
        rd_req(1, 32'h400, 127);

        repeat (5) @(negedge clk);
        chk("ic_exp_drained", 64'(ic_exp.size()), 0);
        chk("dc_exp_drained", 64'(dc_exp.size()), 0);
        chk("aw_exp_drained", 64'(aw_exp.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
